nonce_scanner: RTL and testbench

NONCE_SCANNER -- requirements
Module: nonce_scanner

---
 rtl/nonce_scanner.sv | 116 +++++++++++
 tb/tb_nonce_scanner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scanner.sv
// nonce_scanner: walks a nonce range through a double-SHA stage until a hash <= target is found.
// Optional watchdog on the WAIT state is enabled with NONCE_SCANNER_WATCHDOG_EN.
module nonce_scanner #(
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [607:0] header_prefix,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_limit,
  input  logic [255:0] target,
  output logic [639:0] block,
  output logic         miner_rst,
  input  logic [255:0] miner_hashed,
  input  logic         miner_done,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         timeout,
  output logic [31:0]  golden_nonce,
  output logic [255:0] golden_hash
);
  typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT, CHECK, DONE} state_t;
  state_t state;
  logic [31:0] nonce, limit;
  logic [255:0] tgt;
  logic settled;
`ifdef NONCE_SCANNER_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(WATCHDOG_CYCLES - 1);
  logic [WW-1:0] wd;
`else
  assign timeout = 1'b0;
`endif

  function automatic logic [31:0] bswap(input logic [31:0] n);
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
  endfunction

  assign busy = !(state inside {IDLE, DONE});
  assign miner_rst = state inside {IDLE, KICK, DONE};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      block <= '0;
      nonce <= '0;
      limit <= '0;
      tgt <= '0;
      settled <= 1'b0;
      found <= 1'b0;
      exhausted <= 1'b0;
      golden_nonce <= '0;
      golden_hash <= '0;
`ifdef NONCE_SCANNER_WATCHDOG_EN
      timeout <= 1'b0;
      wd <= '0;
`endif
    end else if (abort && busy) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          block <= {header_prefix, bswap(nonce_start)};
          nonce <= nonce_start;
          limit <= nonce_limit;
          tgt <= target;
          found <= 1'b0;
          exhausted <= 1'b0;
`ifdef NONCE_SCANNER_WATCHDOG_EN
          timeout <= 1'b0;
`endif
          state <= LOAD;
        end
        LOAD: state <= KICK;
        KICK: begin
          settled <= 1'b0;
`ifdef NONCE_SCANNER_WATCHDOG_EN
          wd <= '0;
`endif
          state <= WAIT;
        end
        // miner_done in the first WAIT cycle is left over from the previous nonce
        WAIT: begin
          settled <= 1'b1;
`ifdef NONCE_SCANNER_WATCHDOG_EN
          wd <= wd + 1'b1;
          if (settled && miner_done) state <= CHECK;
          else if (wd == WD_LAST) begin
            timeout <= 1'b1;
            state <= DONE;
          end
`else
          if (settled && miner_done) state <= CHECK;
`endif
        end
        CHECK: if (miner_hashed <= tgt) begin
          golden_nonce <= nonce;
          golden_hash <= miner_hashed;
          found <= 1'b1;
          state <= DONE;
        end else if (nonce == limit) begin
          exhausted <= 1'b1;
          state <= DONE;
        end else begin
          nonce <= nonce + 32'd1;
          block[31:0] <= bswap(nonce + 32'd1);
          state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nonce_scanner.sv
// tb_nonce_scanner: randomized scoreboard bench with a behavioural miner and range-walk model.
module tb_nonce_scanner;
  logic clk = 0, rst, start, abort, miner_done;
  logic [607:0] header_prefix;
  logic [31:0] nonce_start, nonce_limit, golden_nonce;
  logic [255:0] target, miner_hashed, golden_hash;
  logic [639:0] block;
  logic miner_rst, busy, found, exhausted, timeout;

  nonce_scanner #(.WATCHDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .header_prefix(header_prefix),
    .nonce_start(nonce_start), .nonce_limit(nonce_limit), .target(target), .block(block),
    .miner_rst(miner_rst), .miner_hashed(miner_hashed), .miner_done(miner_done), .busy(busy),
    .found(found), .exhausted(exhausted), .timeout(timeout), .golden_nonce(golden_nonce),
    .golden_hash(golden_hash)
  );

  always #5 clk = ~clk;

  typedef struct {logic f, e, t; logic [31:0] gn; logic [255:0] gh;} res_t;
  logic [639:0] kick_q[$];
  res_t res_q[$];
  res_t mon_r;
  int vectors = 0, miscompares = 0;
  logic [255:0] m_tgt, m_hit_hash, gh_ref = '0;
  logic [31:0] m_hit, cur_n, gn_ref = '0;
  bit m_hit_en = 0, m_stuck = 0, stale_en = 0;
  int dly_max = 3, ph = 0, dly = 0;
  logic busy_q = 0;

  function automatic logic [31:0] bswap(logic [31:0] n);
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
  endfunction

  // the stage's answer for a nonce: only the chosen hit nonce hashes at or below the target
  function automatic logic [255:0] hash_of(logic [31:0] n);
    return (m_hit_en && n == m_hit) ? m_hit_hash : m_tgt + 256'd1 + 256'(n);
  endfunction

  task automatic chk(input string nm, input logic [639:0] got, input logic [639:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // miner model: after a kick it keeps the stale done level for one WAIT cycle, then answers after dly cycles
  initial begin
    miner_done = 0;
    miner_hashed = '0;
    forever begin
      @(posedge clk); #1;
      if (rst || !busy) ph = 0;
      else if (miner_rst) begin
        cur_n = bswap(block[31:0]);
        ph = 1;
        dly = $urandom_range(0, dly_max);
        miner_done = stale_en;
        miner_hashed = '0;
      end else if (ph == 1) ph = 2;
      else if (ph == 2) begin
        if (dly == 0 && !m_stuck) begin
          miner_done = 1;
          miner_hashed = hash_of(cur_n);
          ph = 3;
        end else begin
          miner_done = 0;
          dly--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (busy && miner_rst) begin
      if (kick_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL kick_unexpected: got block %h expected no kick", block);
      end else chk("kick_block", block, kick_q.pop_front());
    end
    if (busy_q && !busy) begin
      if (res_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL result_unexpected: got found=%b exhausted=%b expected no completion", found, exhausted);
      end else begin
        mon_r = res_q.pop_front();
        chk("found", found, mon_r.f);
        chk("exhausted", exhausted, mon_r.e);
        chk("timeout", timeout, mon_r.t);
        chk("golden_nonce", golden_nonce, mon_r.gn);
        chk("golden_hash", golden_hash, mon_r.gh);
      end
    end
    busy_q <= busy;
  end

  task automatic pulse_start(input logic [607:0] hdr, input logic [31:0] s, l, input logic [255:0] tg);
    header_prefix = hdr; nonce_start = s; nonce_limit = l; target = tg;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("start_clears_flags", {found, exhausted, timeout}, 3'b000);
  endtask

  task automatic wait_idle();
    int b = 0;
    do begin @(negedge clk); b++; end while (busy && b < 600);
    if (busy) begin
      vectors++; miscompares++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", b);
    end
  endtask

  task automatic run_scan(input logic [607:0] hdr, input logic [31:0] s, l, input logic [255:0] tg,
                          input bit hen, input logic [31:0] hn, input logic [255:0] hh, input bit poke);
    res_t r;
    int unsigned cnt;
    logic [31:0] n;
    m_tgt = tg; m_hit_en = hen; m_hit = hn; m_hit_hash = hh;
    r = '{f:0, e:0, t:0, gn:gn_ref, gh:gh_ref};
    cnt = l - s + 32'd1;
    for (int unsigned i = 0; i < cnt; i++) begin
      n = s + i;
      kick_q.push_back({hdr, bswap(n)});
      if (hen && n == hn) begin
        r.f = 1; r.gn = n; r.gh = hh;
        break;
      end
    end
    r.e = !r.f;
    gn_ref = r.gn; gh_ref = r.gh;
    res_q.push_back(r);
    pulse_start(hdr, s, l, tg);
    if (poke) begin
      repeat (2) @(posedge clk);
      #1 start = 1; header_prefix = ~hdr; nonce_start = s + 32'd100;
      @(posedge clk); #1 start = 0;
    end
    wait_idle();
  endtask

  logic [607:0] hdr;
  logic [255:0] tg;
  logic [31:0] s;
  int b;

  initial begin
    rst = 1; start = 1; abort = 0;
    header_prefix = '1; nonce_start = 0; nonce_limit = 0; target = '1;
    repeat (3) @(posedge clk);
    #1 rst = 0; start = 0;
    @(negedge clk);
    chk("rst_block", block, '0);
    chk("rst_miner_rst", miner_rst, 1'b1);
    chk("rst_busy_flags", {busy, found, exhausted, timeout}, 4'b0);
    chk("rst_golden", {golden_nonce, golden_hash}, '0);

    for (int i = 0; i < 19; i++) hdr[i*32 +: 32] = $urandom;
    run_scan(hdr, 32'h12345678, 32'h12345678, {1'b0, 255'($urandom)}, 1, 32'h12345678, '0, 0);
    chk("single_nonce_block", block[31:0], 32'h78563412);
    run_scan(hdr, 32'hFFFFFFFE, 32'h00000001, '0, 0, 0, '0, 0);

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 19; i++) hdr[i*32 +: 32] = $urandom;
      for (int i = 0; i < 8; i++) tg[i*32 +: 32] = $urandom;
      tg[255] = 0;
      if (k % 4 == 3) tg = tg >> $urandom_range(1, 250);
      s = (k % 6 == 5) ? 32'hFFFFFFFF - 32'($urandom_range(0, 2)) : $urandom;
      stale_en = $urandom_range(0, 1) == 1;
      run_scan(hdr, s, s + 32'($urandom_range(0, 4)), tg, $urandom_range(0, 2) != 0,
               s + 32'($urandom_range(0, 6)), $urandom_range(0, 1) ? tg : tg & {8{$urandom}},
               $urandom_range(0, 2) == 0);
    end

    // abort lands in the same cycle CHECK sees a hit
    stale_en = 0; dly_max = 2;
    m_tgt = 256'h1000; m_hit_en = 1; m_hit = 32'hA5A5A5A5; m_hit_hash = 256'h10;
    kick_q.push_back({hdr, bswap(32'hA5A5A5A5)});
    res_q.push_back('{f:0, e:0, t:0, gn:gn_ref, gh:gh_ref});
    pulse_start(hdr, 32'hA5A5A5A5, 32'hA5A5A5A5, 256'h1000);
    b = 0;
    do begin @(negedge clk); b++; end while (ph != 3 && b < 50);
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abort_idle", {busy, found, miner_rst}, 3'b001);

    // reset in the middle of WAIT
    dly_max = 30;
    m_hit_en = 0;
    kick_q.push_back({~hdr, bswap(32'h00C0FFEE)});
    res_q.push_back('{f:0, e:0, t:0, gn:'0, gh:'0});
    gn_ref = '0; gh_ref = '0;
    pulse_start(~hdr, 32'h00C0FFEE, 32'h00C0FFEE, 256'h1);
    b = 0;
    do begin @(negedge clk); b++; end while (ph != 2 && b < 50);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("wait_rst_block", block, '0);
    chk("wait_rst_outputs", {busy, miner_rst, found, exhausted, timeout}, 5'b01000);
    chk("wait_rst_golden", {golden_nonce, golden_hash}, '0);
    dly_max = 3;

`ifdef NONCE_SCANNER_WATCHDOG_EN
    m_stuck = 1;
    kick_q.push_back({hdr, bswap(32'h5)});
    res_q.push_back('{f:0, e:0, t:1, gn:gn_ref, gh:gh_ref});
    pulse_start(hdr, 32'h5, 32'h9, '1);
    b = 0;
    do begin @(negedge clk); b++; end while (!(busy && miner_rst) && b < 50);
    b = 0;
    do begin @(negedge clk); b++; end while (!timeout && b < 50);
    chk("watchdog_cycles", 32'(b), 32'd9);
    m_stuck = 0;
    wait_idle();
`endif

    repeat (3) @(negedge clk);
    chk("queues_drained", 640'(kick_q.size() + res_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
